// File: rtl/melody_req_ctrl_if.sv
// -----------------------------------------------------------------------------
// melody_req_ctrl_if
//   Signal bundle between the vending/buzzer side and melody_req_ctrl.
//
//   vend_done   1  1-cycle pulse: goods dispensed  -> request song 1
//   refund_done 1  1-cycle pulse: refund paid out  -> request song 2
//   mute        1  level: abort playback and refuse new requests
//   end_note    1  1-cycle pulse from buzzer_ctrl: one song pass complete
//   work_en     2  song select to buzzer_ctrl (0 off, 1 song 1, 2 song 2)
//   busy        1  controller is playing or in its silent gap
//   play_done   1  1-cycle pulse: request finished all repeats
//   req_drop    1  1-cycle pulse: a request (or a timed-out song) was lost
//
//   master : the environment driving events (testbench / system glue)
//   slave  : the melody_req_ctrl block
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface melody_req_ctrl_if;
  logic       vend_done;
  logic       refund_done;
  logic       mute;
  logic       end_note;
  logic [1:0] work_en;
  logic       busy;
  logic       play_done;
  logic       req_drop;

  modport master (
    output vend_done, refund_done, mute, end_note,
    input  work_en, busy, play_done, req_drop
  );

  modport slave (
    input  vend_done, refund_done, mute, end_note,
    output work_en, busy, play_done, req_drop
  );
endinterface

// File: rtl/melody_req_ctrl.sv
// -----------------------------------------------------------------------------
// melody_req_ctrl
//   Song-request sequencer in front of buzzer_ctrl. One-cycle vending events
//   become a held 2-bit song select (work_en). The select is held until
//   buzzer_ctrl has reported end_note REPEAT_CNT times, then a silent gap of
//   GAP_CYCLES+1 cycles is inserted. One further request can wait in a
//   single-entry pending slot while a song plays or the gap runs.
//
// Ports
//   clk            in  system clock (50 MHz)
//   rst            in  asynchronous reset, active-high
//   bus (slave)    vend_done, refund_done, mute, end_note in;
//                  work_en, busy, play_done, req_drop out (all registered)
//
// Parameters
//   REPEAT_CNT      plays per request (1..7, 0 behaves as 1)
//   GAP_CYCLES      silent-gap terminal count
//   TIMEOUT_CYCLES  watchdog terminal count (only used with the macro below)
//
// Optional feature
//   `define MELODY_TIMEOUT_EN  adds a PLAY watchdog; on expiry the song is
//   abandoned as if its last end_note arrived, play_done is suppressed and
//   req_drop pulses instead. Without the macro PLAY waits for end_note
//   indefinitely (mute or rst are the only ways out).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module melody_req_ctrl #(
  parameter logic [2:0]  REPEAT_CNT     = 3'd1,
  parameter logic [24:0] GAP_CYCLES     = 25'd4_999_999,
  parameter logic [27:0] TIMEOUT_CYCLES = 28'd199_999_999
) (
  input  logic               clk,
  input  logic               rst,
  melody_req_ctrl_if.slave   bus
);

  localparam logic [1:0] SONG_OFF = 2'd0;
  localparam logic [1:0] SONG_1   = 2'd1;
  localparam logic [1:0] SONG_2   = 2'd2;

  // Index of the final pass; REPEAT_CNT of 0 is folded onto 1 play.
  localparam logic [2:0] REP_LAST = (REPEAT_CNT == 3'd0) ? 3'd0 : (REPEAT_CNT - 3'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] song;
    logic       drop;
  } slot_t;

  // Offer this cycle's requests to the pending slot. vend is taken first so a
  // simultaneous vend+refund into an empty slot keeps song 1 and drops song 2.
  // A request for the song already waiting merges silently.
  function automatic slot_t offer_slot(input logic       vld,
                                       input logic [1:0] song,
                                       input logic       want1,
                                       input logic       want2);
    slot_t r;
    r.vld  = vld;
    r.song = song;
    r.drop = 1'b0;
    if (want1) begin
      if (!r.vld) begin
        r.vld  = 1'b1;
        r.song = SONG_1;
      end else if (r.song != SONG_1) begin
        r.drop = 1'b1;
      end
    end
    if (want2) begin
      if (!r.vld) begin
        r.vld  = 1'b1;
        r.song = SONG_2;
      end else if (r.song != SONG_2) begin
        r.drop = 1'b1;
      end
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  work_en_q, work_en_d;
  logic        busy_q, busy_d;
  logic        play_done_q, play_done_d;
  logic        req_drop_q, req_drop_d;
  logic [2:0]  rep_cnt_q, rep_cnt_d;
  logic [24:0] gap_cnt_q, gap_cnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic [1:0]  pend_song_q, pend_song_d;

`ifdef MELODY_TIMEOUT_EN
  logic [27:0] wdog_q, wdog_d;
`else
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  logic        req_any;
  logic        req_both;
  logic [1:0]  req_song;
  logic        gap_term;
  slot_t       slot;

  assign req_any  = bus.vend_done | bus.refund_done;
  assign req_both = bus.vend_done & bus.refund_done;
  assign req_song = bus.vend_done ? SONG_1 : SONG_2;
  assign gap_term = (gap_cnt_q == GAP_CYCLES);
  assign slot     = offer_slot(pend_vld_q, pend_song_q, bus.vend_done, bus.refund_done);

  // ---------------------------------------------------------------------------
  // Next-state and next-output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    work_en_d   = work_en_q;
    play_done_d = 1'b0;
    req_drop_d  = 1'b0;
    rep_cnt_d   = rep_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_song_d = pend_song_q;
`ifdef MELODY_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif

    if (bus.mute) begin
      // Mute wins over everything: silence now, forget queued work, and flag
      // any request that tries to get in while muted.
      state_d     = IDLE;
      work_en_d   = SONG_OFF;
      rep_cnt_d   = 3'd0;
      gap_cnt_d   = 25'd0;
      pend_vld_d  = 1'b0;
      pend_song_d = SONG_OFF;
      req_drop_d  = req_any;
`ifdef MELODY_TIMEOUT_EN
      wdog_d      = 28'd0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_any) begin
            state_d   = PLAY;
            work_en_d = req_song;
            rep_cnt_d = 3'd0;
`ifdef MELODY_TIMEOUT_EN
            wdog_d    = 28'd0;
`endif
            if (req_both) begin
              pend_vld_d  = 1'b1;
              pend_song_d = SONG_2;
            end
          end
        end

        PLAY: begin
          pend_vld_d  = slot.vld;
          pend_song_d = slot.song;
          req_drop_d  = slot.drop;
          if (bus.end_note) begin
`ifdef MELODY_TIMEOUT_EN
            wdog_d = 28'd0;
`endif
            if (rep_cnt_q == REP_LAST) begin
              state_d     = GAP;
              work_en_d   = SONG_OFF;
              play_done_d = 1'b1;
              rep_cnt_d   = 3'd0;
              gap_cnt_d   = 25'd0;
            end else begin
              rep_cnt_d = rep_cnt_q + 3'd1;
            end
          end
`ifdef MELODY_TIMEOUT_EN
          else if (wdog_q == TIMEOUT_CYCLES) begin
            // buzzer_ctrl stopped answering: abandon the song without
            // claiming completion and report it as lost.
            state_d    = GAP;
            work_en_d  = SONG_OFF;
            req_drop_d = 1'b1;
            rep_cnt_d  = 3'd0;
            gap_cnt_d  = 25'd0;
            wdog_d     = 28'd0;
          end else begin
            wdog_d = wdog_q + 28'd1;
          end
`endif
        end

        GAP: begin
          if (!gap_term) begin
            gap_cnt_d   = gap_cnt_q + 25'd1;
            pend_vld_d  = slot.vld;
            pend_song_d = slot.song;
            req_drop_d  = slot.drop;
          end else begin
            gap_cnt_d = 25'd0;
            rep_cnt_d = 3'd0;
`ifdef MELODY_TIMEOUT_EN
            wdog_d    = 28'd0;
`endif
            if (pend_vld_q) begin
              // Queued song goes straight out with no idle cycle; anything
              // arriving on this same edge has nowhere to wait.
              state_d     = PLAY;
              work_en_d   = pend_song_q;
              pend_vld_d  = 1'b0;
              pend_song_d = SONG_OFF;
              req_drop_d  = req_any;
            end else if (req_any) begin
              state_d   = PLAY;
              work_en_d = req_song;
              if (req_both) begin
                pend_vld_d  = 1'b1;
                pend_song_d = SONG_2;
              end
            end else begin
              state_d = IDLE;
            end
          end
        end

        default: begin
          state_d     = IDLE;
          work_en_d   = SONG_OFF;
          rep_cnt_d   = 3'd0;
          gap_cnt_d   = 25'd0;
          pend_vld_d  = 1'b0;
          pend_song_d = SONG_OFF;
        end
      endcase
    end

    busy_d = (state_d == PLAY) || (state_d == GAP);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      work_en_q   <= SONG_OFF;
      busy_q      <= 1'b0;
      play_done_q <= 1'b0;
      req_drop_q  <= 1'b0;
      rep_cnt_q   <= 3'd0;
      gap_cnt_q   <= 25'd0;
      pend_vld_q  <= 1'b0;
      pend_song_q <= SONG_OFF;
`ifdef MELODY_TIMEOUT_EN
      wdog_q      <= 28'd0;
`endif
    end else begin
      state_q     <= state_d;
      work_en_q   <= work_en_d;
      busy_q      <= busy_d;
      play_done_q <= play_done_d;
      req_drop_q  <= req_drop_d;
      rep_cnt_q   <= rep_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_song_q <= pend_song_d;
`ifdef MELODY_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign bus.work_en   = work_en_q;
  assign bus.busy      = busy_q;
  assign bus.play_done = play_done_q;
  assign bus.req_drop  = req_drop_q;

endmodule

// File: tb/tb_melody_req_ctrl.sv
`timescale 1ns/1ps

module tb_melody_req_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  melody_req_ctrl_if bus ();

  melody_req_ctrl #(
    .REPEAT_CNT     (3'd2),
    .GAP_CYCLES     (25'd4),
    .TIMEOUT_CYCLES (28'd20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [1:0] we, input logic bsy,
                      input logic pd, input logic rd);
    chk({tag, ".work_en"},   {30'd0, bus.work_en},   {30'd0, we});
    chk({tag, ".busy"},      {31'd0, bus.busy},      {31'd0, bsy});
    chk({tag, ".play_done"}, {31'd0, bus.play_done}, {31'd0, pd});
    chk({tag, ".req_drop"},  {31'd0, bus.req_drop},  {31'd0, rd});
  endtask

  // One end_note pulse, sampled on the next edge.
  task automatic note();
    bus.end_note = 1'b1;
    tick();
    bus.end_note = 1'b0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.vend_done   = 1'b0;
    bus.refund_done = 1'b0;
    bus.mute        = 1'b0;
    bus.end_note    = 1'b0;

    // Reset state
    tick();
    tick();
    outs("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    outs("post_reset", 2'd0, 1'b0, 1'b0, 1'b0);

    // end_note is ignored while idle
    note();
    outs("idle_end_note", 2'd0, 1'b0, 1'b0, 1'b0);

    // Single vend request, two passes, then a 5-cycle gap
    bus.vend_done = 1'b1;
    tick();
    bus.vend_done = 1'b0;
    outs("vend_start", 2'd1, 1'b1, 1'b0, 1'b0);
    note();
    outs("vend_pass1", 2'd1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    outs("vend_hold", 2'd1, 1'b1, 1'b0, 1'b0);
    note();
    outs("vend_done_pulse", 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    outs("gap1", 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    outs("gap_last", 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    outs("gap_to_idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // vend + refund together: song 1 twice, gap, then song 2 back-to-back
    bus.vend_done   = 1'b1;
    bus.refund_done = 1'b1;
    tick();
    bus.vend_done   = 1'b0;
    bus.refund_done = 1'b0;
    outs("both_start", 2'd1, 1'b1, 1'b0, 1'b0);
    note();
    note();
    outs("both_s1_done", 2'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    outs("both_gap_end", 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    outs("both_s2_start", 2'd2, 1'b1, 1'b0, 1'b0);
    note();
    outs("both_s2_pass1", 2'd2, 1'b1, 1'b0, 1'b0);
    note();
    outs("both_s2_done", 2'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    outs("both_idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Pending slot: store, drop different song, merge same song
    bus.vend_done = 1'b1;
    tick();
    bus.vend_done   = 1'b0;
    bus.refund_done = 1'b1;
    tick();
    bus.refund_done = 1'b0;
    outs("pend_store", 2'd1, 1'b1, 1'b0, 1'b0);
    bus.vend_done = 1'b1;
    tick();
    bus.vend_done = 1'b0;
    outs("pend_drop", 2'd1, 1'b1, 1'b0, 1'b1);
    tick();
    outs("pend_drop_clear", 2'd1, 1'b1, 1'b0, 1'b0);
    bus.refund_done = 1'b1;
    tick();
    bus.refund_done = 1'b0;
    outs("pend_merge", 2'd1, 1'b1, 1'b0, 1'b0);
    note();
    note();
    outs("pend_s1_done", 2'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    outs("pend_s2_start", 2'd2, 1'b1, 1'b0, 1'b0);

    // Mute in PLAY with a request pending, then a request during mute
    bus.vend_done = 1'b1;
    tick();
    bus.vend_done = 1'b0;
    outs("mute_pre", 2'd2, 1'b1, 1'b0, 1'b0);
    bus.mute = 1'b1;
    tick();
    outs("mute_abort", 2'd0, 1'b0, 1'b0, 1'b0);
    bus.vend_done = 1'b1;
    tick();
    bus.vend_done = 1'b0;
    bus.mute      = 1'b0;
    outs("mute_req_drop", 2'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    outs("mute_stays_idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Watchdog behaviour (present only with the optional feature)
    bus.vend_done = 1'b1;
    tick();
    bus.vend_done = 1'b0;
    outs("wd_start", 2'd1, 1'b1, 1'b0, 1'b0);
`ifdef MELODY_TIMEOUT_EN
    for (int i = 0; i < 20; i++) tick();
    outs("wd_last_play", 2'd1, 1'b1, 1'b0, 1'b0);
    tick();
    outs("wd_expire", 2'd0, 1'b1, 1'b0, 1'b1);
    tick();
    outs("wd_gap", 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    outs("wd_idle", 2'd0, 1'b0, 1'b0, 1'b0);
`else
    for (int i = 0; i < 30; i++) tick();
    outs("no_wd_hold", 2'd1, 1'b1, 1'b0, 1'b0);
    bus.mute = 1'b1;
    tick();
    bus.mute = 1'b0;
    outs("no_wd_mute_exit", 2'd0, 1'b0, 1'b0, 1'b0);
`endif

    // Asynchronous reset mid-PLAY with the pending slot full
    bus.vend_done   = 1'b1;
    bus.refund_done = 1'b1;
    tick();
    bus.vend_done   = 1'b0;
    bus.refund_done = 1'b0;
    outs("rst_pre", 2'd1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    outs("rst_async", 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    outs("rst_no_replay", 2'd0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
